pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the multicycle ARM-LP core; successor to the fixed 32-bit PC stage.
//  Holds the architectural PC and advances it once per instruction, every STAGES cycles, on a phase counter.
//  Selects sequential, PC-relative (B/CBZ/CBNZ), register-indirect (BR) or external redirect targets.
//  Adds stall, BL link address and alignment-fault reporting.
// PARAMETERS
//  ADDR_WIDTH   32  PC / target width in bits
//  OFFSET_WIDTH 32  width of sign-extended branch offset (in instructions)
//  INSTR_BYTES  4   bytes per instruction; power of 2; offset shift = log2(INSTR_BYTES)
//  STAGES       5   cycles per instruction (>=2); PC commits on phase STAGES-1
//  RESET_VECTOR 0   PC value after reset; must be INSTR_BYTES-aligned
// PORTS
//  clock                   in  1             system clock, rising edge
//  reset_n                 in  1             asynchronous, active-low reset
//  stall                   in  1             1 = freeze phase counter and PC
//  branchFlag              in  1             conditional branch in flight
//  branchOnNonZero         in  1             1 = CBNZ sense, 0 = CBZ sense
//  zeroFlag                in  1             ALU zero result
//  unconditionalBranchFlag in  1             B / BL
//  linkFlag                in  1             BL: capture return address
//  branchRegFlag           in  1             BR: absolute target from register
//  branchRegTarget         in  ADDR_WIDTH    BR target address
//  pcOffsetFilled          in  OFFSET_WIDTH  sign-extended offset, instruction units
//  redirectValid           in  1             external redirect (exception/debug), any phase
//  redirectTarget          in  ADDR_WIDTH    redirect address
//  PC                      out ADDR_WIDTH    current architectural PC
//  phase                   out clog2(STAGES) current phase, 0..STAGES-1
//  pcCommit                out 1             1-cycle pulse: PC updated this edge
//  linkAddr                out ADDR_WIDTH    PC+INSTR_BYTES captured by BL
//  linkValid               out 1             1-cycle pulse with linkAddr update
//  alignFault              out 1             1-cycle pulse: misaligned BR/redirect target
// BEHAVIOUR
//  Reset (async assert, sync release): PC=RESET_VECTOR, phase=0, linkAddr=0, pcCommit=linkValid=alignFault=0.
//  Phase: increments each edge when !stall; wraps STAGES-1 -> 0. stall holds phase and PC; outputs pulses = 0.
//  Commit edge = phase==STAGES-1 && !stall: PC <= nextPC, pcCommit=1 next cycle. Branch inputs sampled only here.
//  nextPC priority (highest first):
//   1 branchRegFlag          -> branchRegTarget
//   2 unconditionalBranchFlag -> PC + (sext(pcOffsetFilled) << log2(INSTR_BYTES))
//   3 branchFlag && (zeroFlag ^ branchOnNonZero) -> same PC-relative target
//   4 otherwise               -> PC + INSTR_BYTES
//  Arithmetic: offset sign-extended/truncated to ADDR_WIDTH before shift; sums modulo 2^ADDR_WIDTH (wrap, no flag).
//  linkFlag && unconditionalBranchFlag at commit: linkAddr <= PC+INSTR_BYTES, linkValid=1 next cycle. linkFlag alone ignored.
//  redirectValid: overrides everything incl. stall, any phase: PC <= redirectTarget, phase <= 0, pcCommit=1.
//  Alignment: BR/redirect target low log2(INSTR_BYTES) bits nonzero -> bits cleared, target still taken, alignFault=1.
//  Simultaneous redirect + commit: redirect wins; no link capture that cycle.
//  Reset mid-instruction: immediate return to reset state; no pending commit survives.
// STRUCTURE
//  Shared package arm_lp_pkg: PC_SRC enum (SEQ, REL, REG, REDIRECT), INSTR_BYTES default, clog2 helper.
//  One sub-module: pc_target_mux (combinational nextPC select + alignment check); phase counter and regs in top.
// TESTING (STAGES=5, ADDR_WIDTH=32, RESET_VECTOR=0)
//  Reset, no branches, 20 cycles -> PC 0,4,8,12 committing at cycles 5,10,15,20; pcCommit pulses align.
//  PC=0x100, branchFlag=1, zeroFlag=1, offset=-2 at commit -> PC=0xF8; with branchOnNonZero=1 -> PC=0x104.
//  PC=0x40, B+linkFlag, offset=3 -> PC=0x4C, linkAddr=0x44, linkValid 1 cycle; BR target 0x203 -> PC=0x200, alignFault.
//  stall held 3 cycles at phase 4 -> commit delayed exactly 3 cycles; PC=0xFFFFFFFC sequential -> 0x0.
//  redirectValid at phase 2 with stall=1, target 0x800 -> PC=0x800, phase=0; reset_n low at phase 3 -> PC=0, phase=0 at once.

Source files
------------

// File: rtl/arm_lp_pkg.sv
// Shared definitions for the ARM-LP multicycle core front end.
package arm_lp_pkg;

  typedef enum logic [1:0] {
    SEQ      = 2'd0,
    REL      = 2'd1,
    REG      = 2'd2,
    REDIRECT = 2'd3
  } pc_src_e;

  localparam int unsigned INSTR_BYTES_DEF = 4;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC selection with alignment checking of absolute targets.
module pc_target_mux
  import arm_lp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 32,
  parameter int unsigned INSTR_BYTES  = INSTR_BYTES_DEF
) (
  input  logic [ADDR_WIDTH-1:0]   i_pc,
  input  logic                    i_redirect,
  input  logic                    i_branch_reg,
  input  logic                    i_uncond,
  input  logic                    i_branch,
  input  logic                    i_on_nonzero,
  input  logic                    i_zero,
  input  logic [ADDR_WIDTH-1:0]   i_reg_target,
  input  logic [ADDR_WIDTH-1:0]   i_redirect_target,
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  output logic [ADDR_WIDTH-1:0]   o_next_pc,
  output logic [ADDR_WIDTH-1:0]   o_seq_pc,
  output logic                    o_align_fault
);

  localparam int unsigned           SHIFT    = clog2(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

  logic [ADDR_WIDTH-1:0] w_off_ext;
  logic [ADDR_WIDTH-1:0] w_rel_pc;
  logic [ADDR_WIDTH-1:0] w_raw;
  pc_src_e               w_src;

  generate
    if (OFFSET_WIDTH >= ADDR_WIDTH) begin : g_trunc
      assign w_off_ext = i_offset[ADDR_WIDTH-1:0];
    end else begin : g_sext
      assign w_off_ext = {{(ADDR_WIDTH-OFFSET_WIDTH){i_offset[OFFSET_WIDTH-1]}}, i_offset};
    end
  endgenerate

  assign o_seq_pc = i_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign w_rel_pc = i_pc + (w_off_ext << SHIFT);

  always_comb begin
    w_src = SEQ;
    if (i_redirect)                             w_src = REDIRECT;
    else if (i_branch_reg)                      w_src = REG;
    else if (i_uncond)                          w_src = REL;
    else if (i_branch && (i_zero ^ i_on_nonzero)) w_src = REL;
  end

  // Only absolute targets can be misaligned; they are forced aligned but still taken.
  always_comb begin
    w_raw         = o_seq_pc;
    o_next_pc     = o_seq_pc;
    o_align_fault = 1'b0;
    case (w_src)
      REDIRECT: w_raw = i_redirect_target;
      REG:      w_raw = i_reg_target;
      REL:      w_raw = w_rel_pc;
      default:  w_raw = o_seq_pc;
    endcase
    if ((w_src == REG) || (w_src == REDIRECT)) begin
      o_next_pc     = w_raw & ~LOW_MASK;
      o_align_fault = |(w_raw & LOW_MASK);
    end else begin
      o_next_pc = w_raw;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC holder: advances once per STAGES-cycle instruction, with stall,
// BL link capture, external redirect and alignment-fault pulses.
module pc_sequencer
  import arm_lp_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           OFFSET_WIDTH = 32,
  parameter int unsigned           INSTR_BYTES  = INSTR_BYTES_DEF,
  parameter int unsigned           STAGES       = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       branchFlag,
  input  logic                       branchOnNonZero,
  input  logic                       zeroFlag,
  input  logic                       unconditionalBranchFlag,
  input  logic                       linkFlag,
  input  logic                       branchRegFlag,
  input  logic [ADDR_WIDTH-1:0]      branchRegTarget,
  input  logic [OFFSET_WIDTH-1:0]    pcOffsetFilled,
  input  logic                       redirectValid,
  input  logic [ADDR_WIDTH-1:0]      redirectTarget,
  output logic [ADDR_WIDTH-1:0]      PC,
  output logic [clog2(STAGES)-1:0]   phase,
  output logic                       pcCommit,
  output logic [ADDR_WIDTH-1:0]      linkAddr,
  output logic                       linkValid,
  output logic                       alignFault
);

  localparam int unsigned   PW         = clog2(STAGES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(STAGES - 1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [PW-1:0]         r_phase;
  logic                  r_commit;
  logic [ADDR_WIDTH-1:0] r_link_addr;
  logic                  r_link_valid;
  logic                  r_fault;

  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic                  w_fault;

  pc_target_mux #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .INSTR_BYTES  (INSTR_BYTES)
  ) u_mux (
    .i_pc              (r_pc),
    .i_redirect        (redirectValid),
    .i_branch_reg      (branchRegFlag),
    .i_uncond          (unconditionalBranchFlag),
    .i_branch          (branchFlag),
    .i_on_nonzero      (branchOnNonZero),
    .i_zero            (zeroFlag),
    .i_reg_target      (branchRegTarget),
    .i_redirect_target (redirectTarget),
    .i_offset          (pcOffsetFilled),
    .o_next_pc         (w_next_pc),
    .o_seq_pc          (w_seq_pc),
    .o_align_fault     (w_fault)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc         <= RESET_VECTOR;
      r_phase      <= '0;
      r_commit     <= 1'b0;
      r_link_addr  <= '0;
      r_link_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_commit     <= 1'b0;
      r_link_valid <= 1'b0;
      r_fault      <= 1'b0;
      // Redirect bypasses stall and the phase counter, and suppresses link capture.
      if (redirectValid) begin
        r_pc     <= w_next_pc;
        r_phase  <= '0;
        r_commit <= 1'b1;
        r_fault  <= w_fault;
      end else if (!stall) begin
        if (r_phase == LAST_PHASE) begin
          r_phase  <= '0;
          r_pc     <= w_next_pc;
          r_commit <= 1'b1;
          r_fault  <= w_fault;
          if (linkFlag && unconditionalBranchFlag) begin
            r_link_addr  <= w_seq_pc;
            r_link_valid <= 1'b1;
          end
        end else begin
          r_phase <= r_phase + PW'(1);
        end
      end
    end
  end

  assign PC         = r_pc;
  assign phase      = r_phase;
  assign pcCommit   = r_commit;
  assign linkAddr   = r_link_addr;
  assign linkValid  = r_link_valid;
  assign alignFault = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instructions push expected commits,
// a negedge monitor pops and compares on every pcCommit pulse.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branchFlag = 1'b0;
  logic        branchOnNonZero = 1'b0;
  logic        zeroFlag = 1'b0;
  logic        unconditionalBranchFlag = 1'b0;
  logic        linkFlag = 1'b0;
  logic        branchRegFlag = 1'b0;
  logic [31:0] branchRegTarget = '0;
  logic [31:0] pcOffsetFilled = '0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic [31:0] PC;
  logic [2:0]  phase;
  logic        pcCommit;
  logic [31:0] linkAddr;
  logic        linkValid;
  logic        alignFault;

  typedef struct {
    logic [31:0] pc;
    logic        lv;
    logic [31:0] la;
    logic        f;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc;

  pc_sequencer #(
    .ADDR_WIDTH   (32),
    .OFFSET_WIDTH (32),
    .INSTR_BYTES  (4),
    .STAGES       (5),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .stall                   (stall),
    .branchFlag              (branchFlag),
    .branchOnNonZero         (branchOnNonZero),
    .zeroFlag                (zeroFlag),
    .unconditionalBranchFlag (unconditionalBranchFlag),
    .linkFlag                (linkFlag),
    .branchRegFlag           (branchRegFlag),
    .branchRegTarget         (branchRegTarget),
    .pcOffsetFilled          (pcOffsetFilled),
    .redirectValid           (redirectValid),
    .redirectTarget          (redirectTarget),
    .PC                      (PC),
    .phase                   (phase),
    .pcCommit                (pcCommit),
    .linkAddr                (linkAddr),
    .linkValid               (linkValid),
    .alignFault              (alignFault)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (pcCommit) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: got PC=%h want no commit", PC);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_cycle", 64'(cyc), 64'(e.cyc));
          chk("pc", 64'(PC), 64'(e.pc));
          chk("linkValid", 64'(linkValid), 64'(e.lv));
          chk("alignFault", 64'(alignFault), 64'(e.f));
          if (e.lv) chk("linkAddr", 64'(linkAddr), 64'(e.la));
        end
      end else if (linkValid || alignFault) begin
        checks++;
        failures++;
        $display("FAIL stray_pulse: got linkValid=%b alignFault=%b want 0 0", linkValid, alignFault);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic lv, input logic [31:0] la,
                      input logic f, input int c);
    exp_t e;
    e.pc = pc; e.lv = lv; e.la = la; e.f = f; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    branchFlag = 0; branchOnNonZero = 0; zeroFlag = 0;
    unconditionalBranchFlag = 0; linkFlag = 0; branchRegFlag = 0;
    branchRegTarget = '0; pcOffsetFilled = '0;
    redirectValid = 0; redirectTarget = '0; stall = 0;
  endtask

  // Called at a negedge with phase 0; leaves phase 0 after the commit.
  task automatic run_instr(input logic br, input logic bnz, input logic z, input logic uc,
                           input logic lk, input logic brg, input logic [31:0] brt,
                           input logic [31:0] off, input logic [31:0] exp_pc,
                           input logic exp_lv, input logic [31:0] exp_la, input logic exp_f);
    push(exp_pc, exp_lv, exp_la, exp_f, cyc + 5);
    branchFlag = br; branchOnNonZero = bnz; zeroFlag = z;
    unconditionalBranchFlag = uc; linkFlag = lk; branchRegFlag = brg;
    branchRegTarget = brt; pcOffsetFilled = off;
    repeat (5) @(negedge clock);
    clear_inputs();
  endtask

  task automatic redirect_to(input logic [31:0] addr, input logic [31:0] exp_pc, input logic exp_f);
    redirectValid = 1; redirectTarget = addr;
    push(exp_pc, 1'b0, '0, exp_f, cyc + 1);
    @(negedge clock);
    redirectValid = 0; redirectTarget = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_pc", 64'(PC), 64'h0);
    chk("rst_phase", 64'(phase), 64'h0);
    chk("rst_pulses", 64'({pcCommit, linkValid, alignFault}), 64'h0);
    chk("rst_linkAddr", 64'(linkAddr), 64'h0);
    reset_n = 1;

    run_instr(0,0,0,0,0,0,'0,'0, 32'h4,  0,'0,0);
    run_instr(0,0,0,0,0,0,'0,'0, 32'h8,  0,'0,0);
    run_instr(0,0,0,0,0,0,'0,'0, 32'hC,  0,'0,0);
    run_instr(0,0,0,0,0,0,'0,'0, 32'h10, 0,'0,0);

    redirect_to(32'h100, 32'h100, 0);
    run_instr(1,0,1,0,0,0,'0,32'hFFFF_FFFE, 32'hF8, 0,'0,0);
    redirect_to(32'h100, 32'h100, 0);
    run_instr(1,1,1,0,0,0,'0,32'hFFFF_FFFE, 32'h104, 0,'0,0);
    run_instr(1,1,0,0,0,0,'0,32'h4, 32'h114, 0,'0,0);

    redirect_to(32'h40, 32'h40, 0);
    run_instr(0,0,0,1,1,0,'0,32'h3, 32'h4C, 1,32'h44,0);
    run_instr(0,0,0,0,0,1,32'h203,'0, 32'h200, 0,'0,1);
    run_instr(0,0,0,0,1,0,'0,32'h7, 32'h204, 0,'0,0);
    run_instr(0,0,0,1,1,1,32'h300,32'h1, 32'h300, 1,32'h208,0);

    redirect_to(32'h802, 32'h800, 1);

    // Stall held three cycles at phase 4, then wrap past the top of memory.
    redirect_to(32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    push(32'h0, 0, '0, 0, cyc + 8);
    repeat (4) @(negedge clock);
    stall = 1;
    chk("stall_phase", 64'(phase), 64'h4);
    repeat (3) @(negedge clock);
    chk("stall_hold_pc", 64'(PC), 64'hFFFF_FFFC);
    stall = 0;
    @(negedge clock);

    // Redirect with stall asserted mid-instruction.
    repeat (2) @(negedge clock);
    stall = 1; redirectValid = 1; redirectTarget = 32'h800;
    push(32'h800, 0, '0, 0, cyc + 1);
    @(negedge clock);
    chk("redir_phase", 64'(phase), 64'h0);
    chk("redir_pc", 64'(PC), 64'h800);
    clear_inputs();

    // Redirect coinciding with a BL commit: redirect wins, no link.
    repeat (4) @(negedge clock);
    unconditionalBranchFlag = 1; linkFlag = 1; pcOffsetFilled = 32'h5;
    redirectValid = 1; redirectTarget = 32'h500;
    push(32'h500, 0, '0, 0, cyc + 1);
    @(negedge clock);
    clear_inputs();
    chk("redir_commit_linkAddr", 64'(linkAddr), 64'h208);

    // Reset mid-instruction at phase 3.
    repeat (3) @(negedge clock);
    chk("pre_reset_phase", 64'(phase), 64'h3);
    reset_n = 0;
    #1;
    chk("midrst_pc", 64'(PC), 64'h0);
    chk("midrst_phase", 64'(phase), 64'h0);
    chk("midrst_linkAddr", 64'(linkAddr), 64'h0);
    @(negedge clock);
    reset_n = 1;
    run_instr(0,0,0,0,0,0,'0,'0, 32'h4, 0,'0,0);

    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
